// File: rtl/rx_edge_sampler_if.sv
// Bundle of signals between the UART RX control FSM and the edge sampler.
// The master side (the FSM, or a bench standing in for it) drives the line,
// the configuration and the enables. The slave side (the sampler) returns
// the synchronised line, the counters and the voted bit.
interface rx_edge_sampler_if #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
);
  logic                  rx_in;
  logic [PRESCALE_W-1:0] prescale;
  logic                  PAR_EN;
  logic                  edge_en;
  logic                  sample_data_en;
  logic                  rx_sync;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  sampled_bit;
  logic                  sample_valid;

  modport master (
    output rx_in, prescale, PAR_EN, edge_en, sample_data_en,
    input  rx_sync, edge_cnt, bit_cnt, sampled_bit, sample_valid
  );

  modport slave (
    input  rx_in, prescale, PAR_EN, edge_en, sample_data_en,
    output rx_sync, edge_cnt, bit_cnt, sampled_bit, sample_valid
  );
endinterface

// File: rtl/rx_edge_sampler.sv
// Timing and sampling front end of the UART receiver. Synchronises the raw
// serial line, counts oversampling edges and bit positions within a frame,
// and produces one majority-voted bit per bit period for the RX FSM.
module rx_edge_sampler #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  rx_edge_sampler_if.slave  bus
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT_NO_PAR = BIT_CNT_W'(9);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT_PAR    = BIT_CNT_W'(10);

  logic                  sync_meta;
  logic                  sync_out;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  sample_0;
  logic                  sample_1;
  logic                  sampled_bit;
  logic                  sample_valid;

  logic [PRESCALE_W-1:0] prescale_m1;
  logic [PRESCALE_W-1:0] mid;
  logic [PRESCALE_W-1:0] mid_m1;
  logic [PRESCALE_W-1:0] mid_p1;
  logic [BIT_CNT_W-1:0]  last_bit;
  logic                  sampling;
  logic                  vote;

  // Sampling window sits around the middle of each bit period; the stop bit
  // index moves out by one when a parity bit is present.
  assign prescale_m1 = bus.prescale - PRESCALE_W'(1);
  assign mid         = bus.prescale >> 1;
  assign mid_m1      = mid - PRESCALE_W'(1);
  assign mid_p1      = mid + PRESCALE_W'(1);
  assign last_bit    = bus.PAR_EN ? LAST_BIT_PAR : LAST_BIT_NO_PAR;
  assign sampling    = bus.sample_data_en && bus.edge_en;

  // The third sample is voted live from rx_sync rather than stored first, so
  // the result lands on the same edge that would have captured it.
  assign vote = (sample_0 & sample_1) | (sample_0 & sync_out) | (sample_1 & sync_out);

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b1;
      sync_out  <= 1'b1;
    end else begin
      sync_meta <= bus.rx_in;
      sync_out  <= sync_meta;
    end
  end

  // Edge counter wraps every prescale clocks; bit counter steps on each wrap
  // and rolls over after the stop bit so frames can run back to back.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!bus.edge_en) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (edge_cnt == prescale_m1) begin
      edge_cnt <= '0;
      if (bit_cnt == last_bit) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      end
    end else begin
      edge_cnt <= edge_cnt + PRESCALE_W'(1);
    end
  end

  // Capture three mid-bit samples and publish their majority with a
  // one-cycle valid pulse that lines up with edge_cnt == mid+2.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_0     <= 1'b1;
      sample_1     <= 1'b1;
      sampled_bit  <= 1'b1;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (sampling) begin
        if (edge_cnt == mid_m1) begin
          sample_0 <= sync_out;
        end
        if (edge_cnt == mid) begin
          sample_1 <= sync_out;
        end
        if (edge_cnt == mid_p1) begin
          sampled_bit  <= vote;
          sample_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.rx_sync      = sync_out;
  assign bus.edge_cnt     = edge_cnt;
  assign bus.bit_cnt      = bit_cnt;
  assign bus.sampled_bit  = sampled_bit;
  assign bus.sample_valid = sample_valid;

endmodule

// File: tb/tb_rx_edge_sampler.sv
// Bench for rx_edge_sampler. Stimulus tasks build a per-cycle picture of the
// serial line, derive the expected voted bits from it with plain arithmetic
// (cycle k of a frame sits at edge k mod prescale of bit k / prescale, and
// the synchronised line is the raw line two cycles late), and queue them.
// A separate monitor pops the queue on every sample_valid pulse.
module tb_rx_edge_sampler;

  localparam int PRESCALE_W = 6;
  localparam int BIT_CNT_W  = 4;

  typedef struct {
    bit value;
    int bitIdx;
    int edgeIdx;
  } expect_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rx_edge_sampler_if #(.PRESCALE_W(PRESCALE_W), .BIT_CNT_W(BIT_CNT_W)) bus ();

  rx_edge_sampler #(.PRESCALE_W(PRESCALE_W), .BIT_CNT_W(BIT_CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  expect_t scoreboard[$];
  expect_t popped;
  bit      line[$];
  int      checks = 0;
  int      errors = 0;
  bit      lastSampled = 1'b1;

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Start a new clock cycle with the given inputs, then move to mid-cycle.
  task automatic applyStimulus(input bit rstV, input bit rxV, input bit enV, input bit sdeV);
    @(posedge clk);
    #1;
    rst                = rstV;
    bus.rx_in          = rxV;
    bus.edge_en        = enV;
    bus.sample_data_en = sdeV;
    @(negedge clk);
  endtask

  // Idle line with enables low; configuration changes only happen here.
  task automatic idle(input int n, input int p, input bit par);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    bus.prescale = PRESCALE_W'(p);
    bus.PAR_EN   = par;
    for (int i = 1; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  function automatic bit majority(input bit a, input bit b, input bit c);
    return (int'(a) + int'(b) + int'(c)) >= 2;
  endfunction

  // Fill the line with whole frames of random data, with occasional
  // single-cycle glitches sprinkled in.
  task automatic genFrames(input int p, input bit par, input int nFrames, input bit glitchy);
    int nb;
    bit v;
    nb = par ? 11 : 10;
    line.delete();
    for (int f = 0; f < nFrames; f++) begin
      for (int b = 0; b < nb; b++) begin
        v = (b == 0) ? 1'b0 : (b == nb - 1) ? 1'b1 : bit'($urandom % 2);
        for (int c = 0; c < p; c++) begin
          line.push_back(v ^ (glitchy && ($urandom % 6 == 0)));
        end
      end
    end
  endtask

  // Queue the expected voted bits for this line, then drive it cycle by
  // cycle with the counters and synchronised line checked each cycle.
  task automatic runFrame(input int p, input bit par, input bit sde, input int nCycles);
    int      mid;
    int      nb;
    expect_t e;
    mid = p / 2;
    nb  = par ? 11 : 10;
    if (sde) begin
      for (int b = 0; b * p + mid + 2 <= nCycles; b++) begin
        e.value   = majority(line[b*p+mid-3], line[b*p+mid-2], line[b*p+mid-1]);
        e.bitIdx  = b % nb;
        e.edgeIdx = mid + 2;
        scoreboard.push_back(e);
        lastSampled = e.value;
      end
    end
    for (int k = 0; k < nCycles; k++) begin
      applyStimulus(1'b0, line[k], 1'b1, sde);
      checkOutput("edge_cnt", 32'(bus.edge_cnt), k % p);
      checkOutput("bit_cnt", 32'(bus.bit_cnt), (k / p) % nb);
      checkOutput("rx_sync", 32'(bus.rx_sync), (k < 2) ? 1 : 32'(line[k-2]));
    end
  endtask

  task automatic zeroLine(input int n);
    line.delete();
    for (int i = 0; i < n; i++) line.push_back(1'b0);
  endtask

  // Monitor: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.sample_valid === 1'b1) begin
      if (scoreboard.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_valid: got sample_valid 1, expected 0 at %0t", $time);
      end else begin
        popped = scoreboard.pop_front();
        checkOutput("sampled_bit", 32'(bus.sampled_bit), 32'(popped.value));
        checkOutput("valid_bit_cnt", 32'(bus.bit_cnt), popped.bitIdx);
        checkOutput("valid_edge_cnt", 32'(bus.edge_cnt), popped.edgeIdx);
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    int p;
    bit par;
    bus.rx_in          = 1'b0;
    bus.prescale       = PRESCALE_W'(8);
    bus.PAR_EN         = 1'b0;
    bus.edge_en        = 1'b0;
    bus.sample_data_en = 1'b0;

    $display("[TB] reset values");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("reset_rx_sync", 32'(bus.rx_sync), 1);
    checkOutput("reset_edge_cnt", 32'(bus.edge_cnt), 0);
    checkOutput("reset_bit_cnt", 32'(bus.bit_cnt), 0);
    checkOutput("reset_sampled_bit", 32'(bus.sampled_bit), 1);
    checkOutput("reset_sample_valid", 32'(bus.sample_valid), 0);

    $display("[TB] prescale 8, line held low");
    idle(4, 8, 1'b0);
    zeroLine(16);
    runFrame(8, 1'b0, 1'b1, 16);

    $display("[TB] single-cycle glitch at the centre sample");
    idle(4, 8, 1'b0);
    zeroLine(8);
    line[2] = 1'b1;
    runFrame(8, 1'b0, 1'b1, 8);
    checkOutput("glitch_rejected", 32'(bus.sampled_bit), 0);

    $display("[TB] two-cycle pulse over centre samples");
    idle(4, 8, 1'b0);
    zeroLine(8);
    line[2] = 1'b1;
    line[3] = 1'b1;
    runFrame(8, 1'b0, 1'b1, 8);
    checkOutput("pulse_accepted", 32'(bus.sampled_bit), 1);

    $display("[TB] sampling disabled, counters still run");
    idle(4, 16, 1'b0);
    genFrames(16, 1'b0, 1, 1'b1);
    runFrame(16, 1'b0, 1'b0, line.size());
    checkOutput("hold_when_disabled", 32'(bus.sampled_bit), 32'(lastSampled));

    $display("[TB] bit_cnt wrap without and with parity");
    idle(4, 16, 1'b0);
    genFrames(16, 1'b0, 2, 1'b0);
    runFrame(16, 1'b0, 1'b1, line.size());
    idle(4, 16, 1'b1);
    genFrames(16, 1'b1, 2, 1'b0);
    runFrame(16, 1'b1, 1'b1, line.size());

    $display("[TB] byte 0xA5 at prescale 32");
    idle(4, 32, 1'b0);
    line.delete();
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 32; c++) begin
        line.push_back((b == 0) ? 1'b0 : (b == 9) ? 1'b1 : bit'((8'hA5 >> (b - 1)) & 8'h01));
      end
    end
    runFrame(32, 1'b0, 1'b1, line.size());

    $display("[TB] reset mid-frame");
    idle(4, 16, 1'b0);
    zeroLine(89);
    runFrame(16, 1'b0, 1'b1, 89);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("pre_reset_edge_cnt", 32'(bus.edge_cnt), 9);
    checkOutput("pre_reset_bit_cnt", 32'(bus.bit_cnt), 5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    lastSampled = 1'b1;
    checkOutput("midreset_edge_cnt", 32'(bus.edge_cnt), 0);
    checkOutput("midreset_bit_cnt", 32'(bus.bit_cnt), 0);
    checkOutput("midreset_sampled_bit", 32'(bus.sampled_bit), 1);
    checkOutput("midreset_sample_valid", 32'(bus.sample_valid), 0);
    checkOutput("midreset_rx_sync", 32'(bus.rx_sync), 1);

    $display("[TB] edge_en dropped mid-frame");
    idle(4, 16, 1'b0);
    zeroLine(89);
    runFrame(16, 1'b0, 1'b1, 89);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("pre_drop_edge_cnt", 32'(bus.edge_cnt), 9);
    checkOutput("pre_drop_bit_cnt", 32'(bus.bit_cnt), 5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("drop_edge_cnt", 32'(bus.edge_cnt), 0);
    checkOutput("drop_bit_cnt", 32'(bus.bit_cnt), 0);
    checkOutput("drop_sampled_bit", 32'(bus.sampled_bit), 32'(lastSampled));
    checkOutput("drop_sample_valid", 32'(bus.sample_valid), 0);

    $display("[TB] randomized frames");
    for (int t = 0; t < 8; t++) begin
      case ($urandom % 3)
        0:       p = 8;
        1:       p = 16;
        default: p = 32;
      endcase
      par = bit'($urandom % 2);
      idle(4, p, par);
      genFrames(p, par, 1 + ($urandom % 2), 1'b1);
      runFrame(p, par, 1'b1, line.size());
    end

    idle(4, 8, 1'b0);
    checkOutput("scoreboard_drained", scoreboard.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
